// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter_if                                                      |
// | CPU / debug requester ports and byte-memory port of dmem_arbiter.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5
);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_ack_o;
  logic              cpu_stall_o;

  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [31:0]       dbg_wdata_i;
  logic [31:0]       dbg_rdata_o;
  logic              dbg_ack_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_ack_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_rdata_o, dbg_ack_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_ack_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_rdata_o, dbg_ack_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter                                                         |
// | Shares a byte-wide data memory between CPU and debug; each word is   |
// | moved as four byte beats, CPU priority with a debug starvation cap.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 32
) (
  input  wire              clk_i,
  input  wire              rst_i,
  dmem_arbiter_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] c_MAX_WAIT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_LAST = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_beat;
  logic              r_sel_dbg;
  logic              r_we;
  logic [ADDR_W-3:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_grant_dbg;
  logic w_grant_cpu;
  logic w_mem_en;
  logic w_cpu_ack;
  logic w_dbg_ack;
  logic w_cpu_stall;
  logic w_unused_addr_lsbs;

  // Debug only overrides CPU priority once it has been bypassed MAX_WAIT times.
  always_comb begin
    w_grant_dbg = 1'b0;
    w_grant_cpu = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        w_grant_dbg = bus.dbg_req_i & ((r_wait_cnt == c_MAX_WAIT) | ~bus.cpu_req_i);
        w_grant_cpu = bus.cpu_req_i & ~w_grant_dbg;
        if (w_grant_dbg | w_grant_cpu) w_state_nxt = S_XFER;
      end
      S_XFER:  if (r_beat == 2'd3) w_state_nxt = S_LAST;
      S_LAST:  w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_beat      <= '0;
      r_sel_dbg   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_cpu_stall) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          r_beat  <= '0;
          r_rdata <= '0;
          if (w_grant_dbg) begin
            r_sel_dbg  <= 1'b1;
            r_we       <= bus.dbg_we_i;
            r_addr     <= bus.dbg_addr_i[ADDR_W-1:2];
            r_wdata    <= bus.dbg_wdata_i;
            r_wait_cnt <= '0;
          end else if (w_grant_cpu) begin
            r_sel_dbg <= 1'b0;
            r_we      <= bus.cpu_we_i;
            r_addr    <= bus.cpu_addr_i[ADDR_W-1:2];
            r_wdata   <= bus.cpu_wdata_i;
            if (bus.dbg_req_i && (r_wait_cnt != c_MAX_WAIT))
              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        S_XFER: begin
          r_beat <= r_beat + 2'd1;
          // Registered memory: the byte returned now belongs to the previous beat.
          if (!r_we && (r_beat != 2'd0))
            r_rdata[{r_beat - 2'd1, 3'b000} +: 8] <= bus.mem_rdata_i;
        end
        S_LAST: begin
          if (!r_we) r_rdata[31:24] <= bus.mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  assign w_mem_en    = (r_state == S_XFER);
  assign w_cpu_ack   = (r_state == S_ACK) & ~r_sel_dbg;
  assign w_dbg_ack   = (r_state == S_ACK) &  r_sel_dbg;
  assign w_cpu_stall = bus.cpu_req_i & ~w_cpu_ack;

  assign bus.mem_en_o    = w_mem_en;
  assign bus.mem_we_o    = w_mem_en & r_we;
  assign bus.mem_addr_o  = w_mem_en ? {r_addr, r_beat} : '0;
  assign bus.mem_wdata_o = w_mem_en ? r_wdata[{r_beat, 3'b000} +: 8] : '0;

  assign bus.cpu_ack_o   = w_cpu_ack;
  assign bus.cpu_rdata_o = (w_cpu_ack & ~r_we) ? r_rdata : '0;
  assign bus.cpu_stall_o = w_cpu_stall;
  assign bus.dbg_ack_o   = w_dbg_ack;
  assign bus.dbg_rdata_o = (w_dbg_ack & ~r_we) ? r_rdata : '0;

  assign stall_cnt_o = r_stall_cnt;

  assign w_unused_addr_lsbs = ^{bus.cpu_addr_i[1:0], bus.dbg_addr_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter                                                      |
// | Directed bench with ack and byte-beat scoreboards for dmem_arbiter.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int ADDR_W = 5;

  typedef struct {
    bit          dbg;
    logic [31:0] rdata;
    int          cyc;
  } ack_t;

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    logic [7:0]  data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] stall_cnt;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic [7:0]  mem [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [7:0]  pl_data;

  ack_t  sb_q[$];
  beat_t bq[$];

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(
    .ADDR_W  (ADDR_W),
    .MAX_WAIT(8),
    .CNT_W   (32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .bus        (bus),
    .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory with one-cycle registered read.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
      bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Ack monitor: winner, returned word, loser quiet, and arrival cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (bus.cpu_ack_o || bus.dbg_ack_o)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_ack actual=cpu%0b/dbg%0b required=none", bus.cpu_ack_o, bus.dbg_ack_o);
      end else begin
        ack_t e;
        e = sb_q.pop_front();
        chk("ack_who", {62'd0, bus.dbg_ack_o, bus.cpu_ack_o}, e.dbg ? 64'd2 : 64'd1);
        chk("ack_rdata", e.dbg ? bus.dbg_rdata_o : bus.cpu_rdata_o, e.rdata);
        chk("loser_rdata", e.dbg ? bus.cpu_rdata_o : bus.dbg_rdata_o, 64'd0);
        chk("ack_cycle", cyc, e.cyc);
      end
    end
  end

  // Beat monitor: every memory strobe must match the next expected byte access.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_en_o) begin
      if (bq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_beat actual=addr%0h required=none", bus.mem_addr_o);
      end else begin
        beat_t b;
        b = bq.pop_front();
        if (b.we)
          chk("beat_wr", {50'd0, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o}, {50'd0, b.we, b.addr, b.data});
        else
          chk("beat_rd", {58'd0, bus.mem_we_o, bus.mem_addr_o}, {58'd0, b.we, b.addr});
      end
    end
  end

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic push_beats(input bit we, input logic [4:0] a, input logic [31:0] wd);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.we   = we;
      b.addr = {a[4:2], 2'(i)};
      b.data = wd[8*i +: 8];
      bq.push_back(b);
    end
  endtask

  task automatic push_ack(input bit dbg, input logic [31:0] rd, input int at);
    ack_t e;
    e.dbg = dbg; e.rdata = rd; e.cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic req_start(input bit dbg, input bit we, input logic [4:0] a, input logic [31:0] wd);
    if (dbg) begin
      bus.dbg_we_i = we; bus.dbg_addr_i = a; bus.dbg_wdata_i = wd; bus.dbg_req_i = 1'b1;
    end else begin
      bus.cpu_we_i = we; bus.cpu_addr_i = a; bus.cpu_wdata_i = wd; bus.cpu_req_i = 1'b1;
    end
  endtask

  task automatic wait_ack_drop(input bit dbg);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = dbg ? bus.dbg_ack_o : bus.cpu_ack_o;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_ack_timeout actual=no ack required=ack within 40 cycles", dbg ? "dbg" : "cpu");
    end
    @(posedge clk); #1;
    if (dbg) bus.dbg_req_i = 1'b0;
    else     bus.cpu_req_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_wdata_i = '0;
    bus.dbg_req_i = 1'b0; bus.dbg_we_i = 1'b0; bus.dbg_addr_i = '0; bus.dbg_wdata_i = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) poke(5'(i), 8'(i));

    @(negedge clk);
    chk("reset_outputs", {47'd0, bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
                          bus.cpu_ack_o, bus.dbg_ack_o, bus.cpu_stall_o}, 64'd0);
    chk("reset_rdata", {bus.cpu_rdata_o, bus.dbg_rdata_o}, 64'd0);
    chk("reset_stall_cnt", stall_cnt, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU write then read of word 0x04.
    push_beats(1'b1, 5'h04, 32'h11223344);
    push_ack(1'b0, 32'h0, cyc + 6);
    req_start(1'b0, 1'b1, 5'h04, 32'h11223344);
    wait_ack_drop(1'b0);
    chk("mem_4_7", {32'd0, mem[7], mem[6], mem[5], mem[4]}, 64'h11223344);
    push_beats(1'b0, 5'h04, 32'h0);
    push_ack(1'b0, 32'h11223344, cyc + 6);
    req_start(1'b0, 1'b0, 5'h04, 32'h0);
    wait_ack_drop(1'b0);
    chk("stall_cnt_12", stall_cnt, 64'd12);

    // Simultaneous requests: CPU first, debug granted right after the CPU ack.
    push_beats(1'b0, 5'h0C, 32'h0);
    push_beats(1'b0, 5'h00, 32'h0);
    push_ack(1'b0, 32'h0F0E0D0C, cyc + 6);
    push_ack(1'b1, 32'h03020100, cyc + 13);
    req_start(1'b0, 1'b0, 5'h0C, 32'h0);
    req_start(1'b1, 1'b0, 5'h00, 32'h0);
    fork
      wait_ack_drop(1'b0);
      wait_ack_drop(1'b1);
    join
    chk("stall_cnt_18", stall_cnt, 64'd18);

    // CPU requests back to back; debug bypassed 8 times then forced through.
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      push_beats(1'b0, 5'h04, 32'h0);
      push_ack(1'b0, 32'h11223344, c0 + 7*k + 6);
    end
    push_beats(1'b0, 5'h10, 32'h0);
    push_ack(1'b1, 32'h13121110, c0 + 62);
    push_beats(1'b0, 5'h04, 32'h0);
    push_ack(1'b0, 32'h11223344, c0 + 69);
    req_start(1'b0, 1'b0, 5'h04, 32'h0);
    req_start(1'b1, 1'b0, 5'h10, 32'h0);
    repeat (55) @(posedge clk); #1;
    chk("wait_cnt_saturated", {60'd0, dut.r_wait_cnt}, 64'd8);
    repeat (2) @(posedge clk); #1;
    chk("wait_cnt_cleared", {60'd0, dut.r_wait_cnt}, 64'd0);
    repeat (6) @(posedge clk); #1;
    bus.dbg_req_i = 1'b0;
    repeat (7) @(posedge clk); #1;
    bus.cpu_req_i = 1'b0;
    @(posedge clk); #1;

    // Unaligned read address selects the containing word.
    poke(5'd8, 8'h01); poke(5'd9, 8'h02); poke(5'd10, 8'h03); poke(5'd11, 8'h04);
    push_beats(1'b0, 5'h08, 32'h0);
    push_ack(1'b0, 32'h04030201, cyc + 6);
    req_start(1'b0, 1'b0, 5'h0B, 32'h0);
    wait_ack_drop(1'b0);

    // Reset during beat 2 of a write abandons the transfer.
    push_beats(1'b1, 5'h10, 32'hAABBCCDD);
    void'(bq.pop_back());
    void'(bq.pop_back());
    req_start(1'b0, 1'b1, 5'h10, 32'hAABBCCDD);
    repeat (3) @(posedge clk); #2;
    chk("beat2_active", {58'd0, bus.mem_en_o, bus.mem_addr_o}, {58'd0, 1'b1, 5'd18});
    #1;
    rst_n = 1'b0;
    bus.cpu_req_i = 1'b0;
    #1;
    chk("reset_drops_en", {63'd0, bus.mem_en_o}, 64'd0);
    @(negedge clk);
    chk("reset_mid_outputs", {62'd0, bus.cpu_ack_o, bus.mem_en_o}, 64'd0);
    chk("reset_mid_stall_cnt", stall_cnt, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    chk("mem_16_19", {32'd0, mem[19], mem[18], mem[17], mem[16]}, 64'h1312CCDD);
    chk("stall_cnt_after_reset", stall_cnt, 64'd0);

    // Request dropped at T+2 still completes.
    push_beats(1'b0, 5'h00, 32'h0);
    push_ack(1'b0, 32'h03020100, cyc + 6);
    req_start(1'b0, 1'b0, 5'h00, 32'h0);
    repeat (2) @(posedge clk); #1;
    bus.cpu_req_i = 1'b0;
    #1;
    chk("stall_low_after_drop", {63'd0, bus.cpu_stall_o}, 64'd0);
    wait_ack_drop(1'b0);
    chk("stall_cnt_drop", stall_cnt, 64'd2);

    repeat (3) @(posedge clk); #1;
    chk("ack_queue_drained", sb_q.size(), 64'd0);
    chk("beat_queue_drained", bq.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
